// File: rtl/rx_packet_check_preamble_pkg.sv
// Shared USB constants, status bit indices and sequencer state encoding.
package rx_packet_check_preamble_pkg;

   localparam int unsigned PID_W    = 4;
   localparam int unsigned ENG_ST_W = 4;
   localparam int unsigned STATUS_W = 6;

   // Token PIDs
   localparam logic [PID_W-1:0] PID_OUT   = 4'h1;
   localparam logic [PID_W-1:0] PID_IN    = 4'h9;
   localparam logic [PID_W-1:0] PID_SOF   = 4'h5;
   localparam logic [PID_W-1:0] PID_SETUP = 4'hD;
   // Data PIDs
   localparam logic [PID_W-1:0] PID_DATA0 = 4'h3;
   localparam logic [PID_W-1:0] PID_DATA1 = 4'hB;
   // Handshake PIDs
   localparam logic [PID_W-1:0] PID_ACK   = 4'h2;
   localparam logic [PID_W-1:0] PID_NAK   = 4'hA;
   localparam logic [PID_W-1:0] PID_STALL = 4'hE;
   // Special PIDs
   localparam logic [PID_W-1:0] PID_PRE   = 4'hC;

   localparam int unsigned LS_TIMEOUT_DEF = 1024;
   localparam int unsigned TO_W_DEF       = 11;

   // rx_cp_status bit positions; [3:0] carries the engine status
   localparam int unsigned STAT_PREAMBLE_SEEN = 5;
   localparam int unsigned STAT_LS_TIMEOUT    = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_LS_ARM,
      ST_LS_WAIT_BUSY,
      ST_LS_WAIT_DONE,
      ST_ABORT_WAIT
   } state_t;

endpackage

// File: rtl/rx_packet_check_preamble_ls_timeout_counter.sv
// Saturating cycle counter guarding the low-speed follower receive.
module rx_packet_check_preamble_ls_timeout_counter
   import rx_packet_check_preamble_pkg::*;
#(
   parameter int unsigned LIMIT = LS_TIMEOUT_DEF,
   parameter int unsigned W     = TO_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired_c
);

   localparam logic [W-1:0] CNT_MAX = '1;
   localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

   logic [W-1:0] count;

   // Count enabled cycles, holding at the top value instead of wrapping
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && (count != CNT_MAX)) begin
         count <= count + W'(1);
      end
   end

   assign expired_c = (count >= LIMIT_W);

endmodule

// File: rtl/rx_packet_check_preamble.sv
// Host receive sequencer: one receive, optionally chased by a low-speed
// follower receive when a PREAMBLE PID comes back.
module rx_packet_check_preamble
   import rx_packet_check_preamble_pkg::*;
#(
   parameter logic [3:0]  PREAMBLE_PID = PID_PRE,
   parameter int unsigned LS_TIMEOUT   = LS_TIMEOUT_DEF,
   parameter int unsigned TO_W         = TO_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rx_cp_en,
   input  logic                preamble_enable,
   output logic                rx_cp_ready,
   output logic                rx_cp_done,
   output logic [PID_W-1:0]    rx_cp_pid,
   output logic [STATUS_W-1:0] rx_cp_status,
   output logic                rx_pkt_en,
   output logic                rx_pkt_abort,
   input  logic                rx_pkt_rdy,
   input  logic [PID_W-1:0]    rx_pkt_pid,
   input  logic [ENG_ST_W-1:0] rx_pkt_status,
   output logic                full_speed_bit_rate,
   output logic                full_speed_polarity,
   output logic                grab_line_control
);

   state_t                state;
   state_t                state_next;

   logic                  ready_next;
   logic                  done_next;
   logic [PID_W-1:0]      pid_next;
   logic [STATUS_W-1:0]   status_next;
   logic                  en_next;
   logic                  abort_next;
   logic                  rate_next;
   logic                  polarity_next;
   logic                  grab_next;

   logic                  to_clear_c;
   logic                  to_enable_c;
   logic                  to_expired_c;
   logic                  preamble_hit_c;

   assign preamble_hit_c = (rx_pkt_pid == PREAMBLE_PID) && preamble_enable &&
                           (rx_pkt_status == '0);
   assign to_enable_c    = (state == ST_LS_ARM) || (state == ST_LS_WAIT_BUSY) ||
                           (state == ST_LS_WAIT_DONE);

   rx_packet_check_preamble_ls_timeout_counter #(
      .LIMIT (LS_TIMEOUT),
      .W     (TO_W)
   ) u_ls_timeout (
      .clk       (clk),
      .rst       (rst),
      .clear     (to_clear_c),
      .enable    (to_enable_c),
      .expired_c (to_expired_c)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= ST_IDLE;
         rx_cp_ready         <= 1'b1;
         rx_cp_done          <= 1'b0;
         rx_cp_pid           <= '0;
         rx_cp_status        <= '0;
         rx_pkt_en           <= 1'b0;
         rx_pkt_abort        <= 1'b0;
         full_speed_bit_rate <= 1'b0;
         full_speed_polarity <= 1'b0;
         grab_line_control   <= 1'b0;
      end else begin
         state               <= state_next;
         rx_cp_ready         <= ready_next;
         rx_cp_done          <= done_next;
         rx_cp_pid           <= pid_next;
         rx_cp_status        <= status_next;
         rx_pkt_en           <= en_next;
         rx_pkt_abort        <= abort_next;
         full_speed_bit_rate <= rate_next;
         full_speed_polarity <= polarity_next;
         grab_line_control   <= grab_next;
      end
   end

   // Next-state logic; a finished LS receive beats a same-cycle timeout
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:         if (rx_cp_en)     state_next = ST_ARM;
         ST_ARM:                            state_next = ST_WAIT_BUSY;
         ST_WAIT_BUSY:    if (!rx_pkt_rdy)  state_next = ST_WAIT_DONE;
         ST_WAIT_DONE:    if (rx_pkt_rdy)   state_next = preamble_hit_c ? ST_LS_ARM : ST_IDLE;
         ST_LS_ARM:                         state_next = ST_LS_WAIT_BUSY;
         ST_LS_WAIT_BUSY: begin
            if (!rx_pkt_rdy)        state_next = ST_LS_WAIT_DONE;
            else if (to_expired_c)  state_next = ST_ABORT_WAIT;
         end
         ST_LS_WAIT_DONE: begin
            if (rx_pkt_rdy)         state_next = ST_IDLE;
            else if (to_expired_c)  state_next = ST_ABORT_WAIT;
         end
         ST_ABORT_WAIT:   if (rx_pkt_rdy)   state_next = ST_IDLE;
         default:                           state_next = ST_IDLE;
      endcase
   end

   // Next-output logic; pulses default low, everything else holds
   always_comb begin
      ready_next    = rx_cp_ready;
      done_next     = 1'b0;
      pid_next      = rx_cp_pid;
      status_next   = rx_cp_status;
      en_next       = 1'b0;
      abort_next    = 1'b0;
      rate_next     = full_speed_bit_rate;
      polarity_next = full_speed_polarity;
      grab_next     = grab_line_control;
      to_clear_c    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rx_cp_en) begin
               ready_next  = 1'b0;
               status_next = '0;
            end
         end
         ST_ARM, ST_LS_ARM: en_next = 1'b1;
         ST_WAIT_DONE: begin
            if (rx_pkt_rdy) begin
               if (preamble_hit_c) begin
                  status_next[STAT_PREAMBLE_SEEN] = 1'b1;
                  grab_next     = 1'b1;
                  rate_next     = 1'b0;
                  polarity_next = 1'b1;
                  to_clear_c    = 1'b1;
               end else begin
                  pid_next                   = rx_pkt_pid;
                  status_next[ENG_ST_W-1:0]  = rx_pkt_status;
                  done_next                  = 1'b1;
                  ready_next                 = 1'b1;
               end
            end
         end
         ST_LS_WAIT_BUSY: begin
            if (rx_pkt_rdy && to_expired_c) begin
               abort_next                   = 1'b1;
               status_next[STAT_LS_TIMEOUT] = 1'b1;
            end
         end
         ST_LS_WAIT_DONE: begin
            if (rx_pkt_rdy) begin
               pid_next                  = rx_pkt_pid;
               status_next[ENG_ST_W-1:0] = rx_pkt_status;
               grab_next                 = 1'b0;
               rate_next                 = 1'b0;
               done_next                 = 1'b1;
               ready_next                = 1'b1;
            end else if (to_expired_c) begin
               abort_next                   = 1'b1;
               status_next[STAT_LS_TIMEOUT] = 1'b1;
            end
         end
         ST_ABORT_WAIT: begin
            if (rx_pkt_rdy) begin
               pid_next                  = '0;
               status_next[ENG_ST_W-1:0] = '0;
               grab_next                 = 1'b0;
               done_next                 = 1'b1;
               ready_next                = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rx_packet_check_preamble.sv
// Bench for rx_packet_check_preamble with a behavioural receive engine.
module tb_rx_packet_check_preamble;
   import rx_packet_check_preamble_pkg::*;

   localparam int LS_TO = 1024;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_cp_en = 1'b0;
   logic       preamble_enable = 1'b0;
   logic       rx_cp_ready, rx_cp_done;
   logic [3:0] rx_cp_pid;
   logic [5:0] rx_cp_status;
   logic       rx_pkt_en, rx_pkt_abort;
   logic       rx_pkt_rdy = 1'b1;
   logic [3:0] rx_pkt_pid = 4'h0;
   logic [3:0] rx_pkt_status = 4'h0;
   logic       full_speed_bit_rate, full_speed_polarity, grab_line_control;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   always #5 clk = ~clk;

   rx_packet_check_preamble dut (
      .clk                 (clk),
      .rst                 (rst),
      .rx_cp_en            (rx_cp_en),
      .preamble_enable     (preamble_enable),
      .rx_cp_ready         (rx_cp_ready),
      .rx_cp_done          (rx_cp_done),
      .rx_cp_pid           (rx_cp_pid),
      .rx_cp_status        (rx_cp_status),
      .rx_pkt_en           (rx_pkt_en),
      .rx_pkt_abort        (rx_pkt_abort),
      .rx_pkt_rdy          (rx_pkt_rdy),
      .rx_pkt_pid          (rx_pkt_pid),
      .rx_pkt_status       (rx_pkt_status),
      .full_speed_bit_rate (full_speed_bit_rate),
      .full_speed_polarity (full_speed_polarity),
      .grab_line_control   (grab_line_control)
   );

   typedef struct {
      logic [3:0] pid;
      logic [3:0] st;
      int         delay;
      bit         hang;
   } resp_t;

   resp_t resp_q[$];

   // Engine model: drops rdy the cycle after it sees an arm, answers from resp_q
   initial begin : engine
      resp_t r;
      forever begin
         @(negedge clk);
         if (rx_pkt_en === 1'b1 && rst !== 1'b1) begin
            @(posedge clk); #1;
            rx_pkt_rdy = 1'b0;
            rx_pkt_pid = 4'($urandom);
            rx_pkt_status = 4'($urandom);
            if (resp_q.size() != 0) r = resp_q.pop_front();
            else begin r.pid = 4'h0; r.st = 4'h0; r.delay = 2; r.hang = 1'b0; end
            if (r.hang) begin
               for (int i = 0; i < 4000; i++) begin
                  @(negedge clk);
                  if (rx_pkt_abort === 1'b1 || rst === 1'b1) break;
               end
               r.pid = 4'h5; r.st = 4'h3; r.delay = 3;
            end
            repeat (r.delay) @(posedge clk);
            #1;
            rx_pkt_pid = r.pid;
            rx_pkt_status = r.st;
            rx_pkt_rdy = 1'b1;
         end
      end
   end

   // Observation counters sampled mid-cycle
   int         cyc = 0, en_cnt = 0, abort_cnt = 0, done_cnt = 0;
   int         grab_cyc = 0, grab_bad = 0, last_en_cyc = 0, abort_cyc = 0;
   int         since_rise = 0, done_lat = 0;
   logic       prev_rdy = 1'b1;
   logic [3:0] done_pid = 4'h0;
   logic [5:0] done_status = 6'h0;
   logic       done_grab = 1'b0, done_ready = 1'b0;

   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (rx_pkt_rdy && !prev_rdy) since_rise = 0; else since_rise++;
         prev_rdy = rx_pkt_rdy;
         if (rx_pkt_en)    begin en_cnt++; last_en_cyc = cyc; end
         if (rx_pkt_abort) begin abort_cnt++; abort_cyc = cyc; end
         if (grab_line_control) begin
            grab_cyc++;
            if (full_speed_bit_rate !== 1'b0 || full_speed_polarity !== 1'b1) grab_bad++;
         end
         if (rx_cp_done) begin
            done_cnt++;
            done_pid    = rx_cp_pid;
            done_status = rx_cp_status;
            done_grab   = grab_line_control;
            done_ready  = rx_cp_ready;
            done_lat    = since_rise;
         end
      end
   end

   task automatic start_rx(input bit pe, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rx_cp_ready) begin ok = 1'b1; break; end
      end
      preamble_enable = pe;
      rx_cp_en = 1'b1;
      @(negedge clk);
      rx_cp_en = 1'b0;
   endtask

   task automatic wait_done(input int start, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (done_cnt > start) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      logic [16:0] got;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      got = {rx_cp_ready, rx_cp_done, rx_cp_pid, rx_cp_status, rx_pkt_en, rx_pkt_abort,
             full_speed_bit_rate, full_speed_polarity, grab_line_control};
      assert_cnt++;
      if (got !== {1'b1, 16'h0}) begin
         fail_cnt++;
         $display("FAIL reset_outputs: got %h expected %h", got, {1'b1, 16'h0});
      end
   endtask

   task automatic test_normal();
      bit ok;
      int e0 = en_cnt, d0 = done_cnt, g0 = grab_cyc;
      resp_q.push_back('{pid: 4'h2, st: 4'h0, delay: 3, hang: 1'b0});
      start_rx(1'b0, ok);
      assert_cnt++;
      if (!ok || rx_cp_ready !== 1'b0 || rx_pkt_en !== 1'b0) begin
         fail_cnt++;
         $display("FAIL normal_accept: ready=%b en=%b expected ready=0 en=0", rx_cp_ready, rx_pkt_en);
      end
      @(negedge clk);
      assert_cnt++;
      if (rx_pkt_en !== 1'b1) begin
         fail_cnt++;
         $display("FAIL normal_arm_latency: rx_pkt_en=%b expected 1", rx_pkt_en);
      end
      wait_done(d0, 100, ok);
      assert_cnt++;
      if (!ok) begin fail_cnt++; $display("FAIL normal_timeout: no done within budget"); end
      @(negedge clk);
      assert_cnt++;
      if (rx_cp_done !== 1'b0 || done_cnt - d0 !== 1) begin
         fail_cnt++;
         $display("FAIL normal_done_pulse: done=%b count=%0d expected 0 and 1", rx_cp_done, done_cnt - d0);
      end
      assert_cnt++;
      if (done_pid !== 4'h2 || done_status !== 6'h00) begin
         fail_cnt++;
         $display("FAIL normal_result: pid=%h status=%h expected 2 00", done_pid, done_status);
      end
      assert_cnt++;
      if (en_cnt - e0 !== 1 || grab_cyc !== g0 || done_ready !== 1'b1 || done_lat !== 1) begin
         fail_cnt++;
         $display("FAIL normal_side: arms=%0d grab_cyc=%0d ready=%b lat=%0d expected 1 0 1 1",
                  en_cnt - e0, grab_cyc - g0, done_ready, done_lat);
      end
   endtask

   task automatic test_preamble_chase();
      bit ok;
      int e0 = en_cnt, d0 = done_cnt, g0 = grab_cyc, b0 = grab_bad;
      resp_q.push_back('{pid: 4'hC, st: 4'h0, delay: 4, hang: 1'b0});
      resp_q.push_back('{pid: 4'h3, st: 4'h0, delay: 5, hang: 1'b0});
      start_rx(1'b1, ok);
      wait_done(d0, 200, ok);
      assert_cnt++;
      if (!ok) begin fail_cnt++; $display("FAIL chase_timeout: no done within budget"); end
      assert_cnt++;
      if (done_pid !== 4'h3 || done_status !== 6'h20) begin
         fail_cnt++;
         $display("FAIL chase_result: pid=%h status=%h expected 3 20", done_pid, done_status);
      end
      assert_cnt++;
      if (en_cnt - e0 !== 2 || grab_cyc == g0 || grab_bad !== b0 || done_grab !== 1'b0 || done_lat !== 1) begin
         fail_cnt++;
         $display("FAIL chase_side: arms=%0d grab_cyc=%0d bad=%0d grab_at_done=%b lat=%0d expected 2 >0 0 0 1",
                  en_cnt - e0, grab_cyc - g0, grab_bad - b0, done_grab, done_lat);
      end
   endtask

   task automatic test_preamble_plain(input bit pe, input logic [3:0] st, input logic [5:0] exp_st);
      bit ok;
      int e0 = en_cnt, d0 = done_cnt;
      resp_q.push_back('{pid: 4'hC, st: st, delay: 2, hang: 1'b0});
      start_rx(pe, ok);
      wait_done(d0, 100, ok);
      assert_cnt++;
      if (!ok || done_pid !== 4'hC || done_status !== exp_st || en_cnt - e0 !== 1) begin
         fail_cnt++;
         $display("FAIL preamble_plain pe=%b: pid=%h status=%h arms=%0d expected C %h 1",
                  pe, done_pid, done_status, en_cnt - e0, exp_st);
      end
   endtask

   task automatic test_ls_timeout();
      bit ok;
      int e0 = en_cnt, d0 = done_cnt, a0 = abort_cnt;
      resp_q.push_back('{pid: 4'hC, st: 4'h0, delay: 2, hang: 1'b0});
      resp_q.push_back('{pid: 4'h0, st: 4'h0, delay: 0, hang: 1'b1});
      start_rx(1'b1, ok);
      wait_done(d0, LS_TO + 200, ok);
      assert_cnt++;
      if (!ok) begin fail_cnt++; $display("FAIL timeout_no_done: no done within budget"); end
      assert_cnt++;
      if (abort_cnt - a0 !== 1 || abort_cyc - last_en_cyc !== LS_TO) begin
         fail_cnt++;
         $display("FAIL timeout_abort: aborts=%0d delay=%0d expected 1 %0d",
                  abort_cnt - a0, abort_cyc - last_en_cyc, LS_TO);
      end
      assert_cnt++;
      if (done_pid !== 4'h0 || done_status !== 6'h30 || done_grab !== 1'b0 || en_cnt - e0 !== 2) begin
         fail_cnt++;
         $display("FAIL timeout_result: pid=%h status=%h grab=%b arms=%0d expected 0 30 0 2",
                  done_pid, done_status, done_grab, en_cnt - e0);
      end
   endtask

   task automatic test_reset_mid_ls();
      bit ok;
      int e0 = en_cnt, d0;
      resp_q.push_back('{pid: 4'hC, st: 4'h0, delay: 2, hang: 1'b0});
      resp_q.push_back('{pid: 4'h0, st: 4'h0, delay: 0, hang: 1'b1});
      start_rx(1'b1, ok);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (en_cnt - e0 >= 2 && !rx_pkt_rdy) break;
      end
      repeat (5) @(negedge clk);
      assert_cnt++;
      if (grab_line_control !== 1'b1) begin
         fail_cnt++;
         $display("FAIL midls_grab: grab=%b expected 1", grab_line_control);
      end
      d0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      assert_cnt++;
      if (rx_cp_ready !== 1'b1 || grab_line_control !== 1'b0 || rx_cp_done !== 1'b0 || rx_cp_status !== 6'h0) begin
         fail_cnt++;
         $display("FAIL midls_reset: ready=%b grab=%b done=%b status=%h expected 1 0 0 00",
                  rx_cp_ready, grab_line_control, rx_cp_done, rx_cp_status);
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
      assert_cnt++;
      if (done_cnt !== d0) begin
         fail_cnt++;
         $display("FAIL midls_no_done: dones=%0d expected 0", done_cnt - d0);
      end
      d0 = done_cnt;
      resp_q.push_back('{pid: 4'hA, st: 4'h0, delay: 2, hang: 1'b0});
      start_rx(1'b1, ok);
      wait_done(d0, 100, ok);
      assert_cnt++;
      if (!ok || done_pid !== 4'hA || done_status !== 6'h00) begin
         fail_cnt++;
         $display("FAIL midls_after: pid=%h status=%h expected A 00", done_pid, done_status);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int e0 = en_cnt;
      resp_q.push_back('{pid: 4'h2, st: 4'h0, delay: 2, hang: 1'b0});
      resp_q.push_back('{pid: 4'hB, st: 4'h1, delay: 3, hang: 1'b0});
      preamble_enable = 1'b0;
      rx_cp_en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin @(negedge clk); if (rx_cp_done) begin ok = 1'b1; break; end end
      assert_cnt++;
      if (!ok || rx_cp_ready !== 1'b1 || rx_cp_pid !== 4'h2 || rx_cp_status !== 6'h00) begin
         fail_cnt++;
         $display("FAIL b2b_first: ready=%b pid=%h status=%h expected 1 2 00", rx_cp_ready, rx_cp_pid, rx_cp_status);
      end
      @(negedge clk);
      assert_cnt++;
      if (rx_cp_ready !== 1'b0 || rx_cp_done !== 1'b0) begin
         fail_cnt++;
         $display("FAIL b2b_restart: ready=%b done=%b expected 0 0", rx_cp_ready, rx_cp_done);
      end
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin @(negedge clk); if (rx_cp_done) begin ok = 1'b1; break; end end
      rx_cp_en = 1'b0;
      assert_cnt++;
      if (!ok || rx_cp_pid !== 4'hB || rx_cp_status !== 6'h01) begin
         fail_cnt++;
         $display("FAIL b2b_second: pid=%h status=%h expected B 01", rx_cp_pid, rx_cp_status);
      end
      repeat (3) @(negedge clk);
      assert_cnt++;
      if (en_cnt - e0 !== 2 || rx_cp_ready !== 1'b1) begin
         fail_cnt++;
         $display("FAIL b2b_arms: arms=%0d ready=%b expected 2 1", en_cnt - e0, rx_cp_ready);
      end
   endtask

   task automatic test_random(input int n);
      bit         ok, pe, pre;
      logic [3:0] p1, s1, p2, s2, exp_pid;
      logic [5:0] exp_st;
      int         e0, d0, exp_arms;
      for (int k = 0; k < n; k++) begin
         pe = 1'($urandom_range(0, 1));
         p1 = ($urandom_range(0, 1) == 1) ? 4'hC : 4'($urandom);
         s1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         p2 = ($urandom_range(0, 3) == 0) ? 4'hC : 4'($urandom);
         s2 = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
         pre = (p1 == 4'hC) && pe && (s1 == 4'h0);
         resp_q.push_back('{pid: p1, st: s1, delay: int'($urandom_range(1, 6)), hang: 1'b0});
         if (pre) resp_q.push_back('{pid: p2, st: s2, delay: int'($urandom_range(1, 6)), hang: 1'b0});
         exp_pid  = pre ? p2 : p1;
         exp_st   = pre ? {2'b10, s2} : {2'b00, s1};
         exp_arms = pre ? 2 : 1;
         e0 = en_cnt;
         d0 = done_cnt;
         start_rx(pe, ok);
         wait_done(d0, 200, ok);
         assert_cnt++;
         if (!ok || done_pid !== exp_pid || done_status !== exp_st || en_cnt - e0 !== exp_arms || done_grab !== 1'b0) begin
            fail_cnt++;
            $display("FAIL random[%0d]: pid=%h status=%h arms=%0d grab=%b expected %h %h %0d 0",
                     k, done_pid, done_status, en_cnt - e0, done_grab, exp_pid, exp_st, exp_arms);
         end
      end
      assert_cnt++;
      if (grab_bad !== 0) begin
         fail_cnt++;
         $display("FAIL random_line_ctrl: bad grab cycles=%0d expected 0", grab_bad);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_preamble_chase();
      test_preamble_plain(1'b0, 4'h0, 6'h00);
      test_preamble_plain(1'b1, 4'h2, 6'h02);
      test_ls_timeout();
      test_reset_mid_ls();
      test_back_to_back();
      test_random(40);
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
